// File: rtl/sym_pkg.sv
// Shared definitions for the symmetry-restore output stage: mode codes,
// fixed-point constants and the clamp helper used on the widened result.
package sym_pkg;

  localparam logic [1:0] SYM_ODD   = 2'b00;
  localparam logic [1:0] SYM_POINT = 2'b01;
  localparam logic [1:0] SYM_EVEN  = 2'b10;

  // Fixed-point 1.0 for a format with n fraction bits.
  function automatic int one_of(input int n);
    return 1 << n;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Clamp a signed value into the range of a w-bit two's-complement word.
  function automatic int sat_w(input int v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

endpackage

// File: rtl/post_sym_restore_sign_fifo.sv
// 1-bit sign queue; data visible the cycle after push (no bypass).
// Pushes when full and pops when empty are ignored.
module sign_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/post_sym_restore.sv
// Pairs queued input signs with core results f(|x|) and rebuilds f(x); 1-cycle registered output.
// Core results stall when no sign is queued or the held output is not being taken.
module post_sym_restore
  import sym_pkg::*;
#(
  parameter int M          = 4,
  parameter int N          = 8,
  parameter int WIDTH      = M + N,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          sign_valid,
  input  logic                          sign_in,
  output logic                          sign_ready,
  input  logic                          y_valid,
  input  logic [WIDTH-1:0]              y_abs,
  output logic                          y_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          err_underflow
);

  localparam logic signed [WIDTH+1:0] ONE_EXT = (WIDTH+2)'(one_of(N));

  logic                      w_full;
  logic                      w_empty;
  logic                      w_head;
  logic                      w_push;
  logic                      w_accept;
  logic signed [WIDTH+1:0]   w_mag;
  logic signed [WIDTH+1:0]   w_ext;
  logic [WIDTH-1:0]          w_sat;
  logic                      r_out_valid;
  logic [WIDTH-1:0]          r_out_data;
  logic                      r_err;

  assign sign_ready = !w_full;
  assign w_push     = sign_valid && sign_ready;
  assign y_ready    = !w_empty && (!r_out_valid || out_ready);
  assign w_accept   = y_valid && y_ready;

  sign_fifo #(.DEPTH(FIFO_DEPTH)) u_sign_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (sign_in),
    .i_pop   (w_accept),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  // Two guard bits keep ONE - y_abs and -y_abs exact before clamping.
  assign w_mag = $signed({2'b00, y_abs});

  always_comb begin
    w_ext = w_mag;
    if (w_head) begin
      case (mode)
        SYM_ODD:   w_ext = -w_mag;
        SYM_POINT: w_ext = ONE_EXT - w_mag;
        default:   w_ext = w_mag;
      endcase
    end
  end

  assign w_sat = WIDTH'(sat_w(int'(w_ext), WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (y_valid && w_empty && !sign_valid) r_err <= 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_post_sym_restore.sv
// Directed bench for post_sym_restore with hand-computed expected outputs.
module tb_post_sym_restore;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        sign_valid;
  logic        sign_in;
  logic        sign_ready;
  logic        y_valid;
  logic [11:0] y_abs;
  logic        y_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready;
  logic [3:0]  occupancy;
  logic        err_underflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  post_sym_restore dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .sign_valid    (sign_valid),
    .sign_in       (sign_in),
    .sign_ready    (sign_ready),
    .y_valid       (y_valid),
    .y_abs         (y_abs),
    .y_ready       (y_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .occupancy     (occupancy),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sign(input logic s);
    sign_valid = 1'b1;
    sign_in    = s;
    tick();
    sign_valid = 1'b0;
  endtask

  // One sign then one core result; output checked one cycle after the accept.
  task automatic xfer(input logic s, input logic [1:0] m, input logic [11:0] y,
                      input logic [11:0] e, input string tag);
    push_sign(s);
    mode    = m;
    y_valid = 1'b1;
    y_abs   = y;
    #1 chk({tag, "_yrdy"}, 32'(y_ready), 32'd1);
    tick();
    y_valid = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(e));
  endtask

  logic [11:0] exp_q[$];
  logic [11:0] seq_y[4];
  logic        fill[8];

  initial begin
    rst = 1'b1; mode = 2'b00; sign_valid = 1'b0; sign_in = 1'b0;
    y_valid = 1'b0; y_abs = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_sign_ready", 32'(sign_ready), 32'd1);
    chk("rst_y_ready", 32'(y_ready), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: odd pipeline, consecutive results at 1-cycle latency.
    push_sign(1'b0); push_sign(1'b1); push_sign(1'b0);
    chk("t1_occ3", 32'(occupancy), 32'd3);
    seq_y[0] = 12'd50; seq_y[1] = 12'd50; seq_y[2] = 12'd2047;
    exp_q = '{12'd50, 12'hFCE, 12'd2047};
    y_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y_abs = seq_y[i];
      #1 chk($sformatf("t1_yrdy%0d", i), 32'(y_ready), 32'd1);
      if (i == 0) chk("t1_pre_vld", 32'(out_valid), 32'd0);
      tick();
      chk($sformatf("t1_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t1_out%0d", i), 32'(out_data), 32'(exp_q[i]));
    end
    y_valid = 1'b0;
    tick();
    chk("t1_drain_vld", 32'(out_valid), 32'd0);
    chk("t1_drain_occ", 32'(occupancy), 32'd0);

    // 2: odd-mode extremes of the unsigned magnitude.
    xfer(1'b1, 2'b00, 12'h800, 12'h800, "t2_neg2048");
    xfer(1'b0, 2'b00, 12'h800, 12'h7FF, "t2_pos_sat");

    // 3: point symmetry, then even (mode 10 and 11).
    mode = 2'b01;
    push_sign(1'b1); push_sign(1'b1); push_sign(1'b0);
    seq_y[0] = 12'd192; seq_y[1] = 12'd256; seq_y[2] = 12'd300;
    exp_q = '{12'd64, 12'd0, 12'd300};
    y_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y_abs = seq_y[i];
      tick();
      chk($sformatf("t3_out%0d", i), 32'(out_data), 32'(exp_q[i]));
    end
    y_valid = 1'b0;
    xfer(1'b1, 2'b01, 12'd4095, 12'h800, "t3_point_sat");
    xfer(1'b1, 2'b10, 12'd100, 12'd100, "t3_even10");
    xfer(1'b1, 2'b11, 12'd100, 12'd100, "t3_even11");
    tick();

    // 4: backpressure with held output; mode wiggled while held.
    mode = 2'b00;
    push_sign(1'b0); push_sign(1'b1); push_sign(1'b0); push_sign(1'b1);
    out_ready = 1'b0;
    y_valid = 1'b1; y_abs = 12'd10;
    tick();
    chk("t4_first", 32'(out_data), 32'd10);
    y_abs = 12'd20;
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_hold_yrdy%0d", i), 32'(y_ready), 32'd0);
      chk($sformatf("t4_hold_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t4_hold_dat%0d", i), 32'(out_data), 32'd10);
      tick();
    end
    chk("t4_hold_occ", 32'(occupancy), 32'd3);
    mode = 2'b00;
    out_ready = 1'b1;
    seq_y[0] = 12'd20; seq_y[1] = 12'd30; seq_y[2] = 12'd40;
    exp_q = '{12'hFEC, 12'd30, 12'hFD8};
    for (int i = 0; i < 3; i++) begin
      y_abs = seq_y[i];
      #1 chk($sformatf("t4_rel_yrdy%0d", i), 32'(y_ready), 32'd1);
      tick();
      chk($sformatf("t4_rel_out%0d", i), 32'(out_data), 32'(exp_q[i]));
    end
    y_valid = 1'b0;
    tick();
    chk("t4_end_vld", 32'(out_valid), 32'd0);

    // 5: fill, overfill attempt, push+pop at 4, drain across wrap.
    fill = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    sign_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sign_in = fill[i];
      tick();
    end
    chk("t5_full_occ", 32'(occupancy), 32'd8);
    chk("t5_full_rdy", 32'(sign_ready), 32'd0);
    sign_in = 1'b1;
    tick();
    sign_valid = 1'b0;
    chk("t5_overfill_occ", 32'(occupancy), 32'd8);
    y_valid = 1'b1; y_abs = 12'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_pop%0d", i), 32'(out_data), fill[i] ? 32'hFFB : 32'd5);
    end
    chk("t5_occ4", 32'(occupancy), 32'd4);
    sign_valid = 1'b1; sign_in = 1'b1; y_abs = 12'd7;
    tick();
    sign_valid = 1'b0;
    chk("t5_pushpop_occ", 32'(occupancy), 32'd4);
    chk("t5_pushpop_out", 32'(out_data), 32'd7);
    y_abs = 12'd9;
    exp_q = '{12'd9, 12'hFF7, 12'd9, 12'hFF7};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_drain%0d", i), 32'(out_data), 32'(exp_q[i]));
    end
    y_valid = 1'b0;
    chk("t5_empty_occ", 32'(occupancy), 32'd0);
    tick();

    // 6: underflow error, then asynchronous reset mid-stream.
    y_valid = 1'b1; y_abs = 12'd33;
    #1 chk("t6_stall_yrdy", 32'(y_ready), 32'd0);
    tick();
    chk("t6_err", 32'(err_underflow), 32'd1);
    chk("t6_no_out", 32'(out_valid), 32'd0);
    y_valid = 1'b0;
    push_sign(1'b1); push_sign(1'b0);
    out_ready = 1'b0;
    y_valid = 1'b1; y_abs = 12'd33;
    tick();
    y_valid = 1'b0;
    chk("t6_pre_rst_vld", 32'(out_valid), 32'd1);
    chk("t6_pre_rst_occ", 32'(occupancy), 32'd1);
    chk("t6_err_sticky", 32'(err_underflow), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(out_valid), 32'd0);
    chk("t6_rst_dat", 32'(out_data), 32'd0);
    chk("t6_rst_occ", 32'(occupancy), 32'd0);
    chk("t6_rst_err", 32'(err_underflow), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t6_post_yrdy", 32'(y_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
